// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - request/response handshake bundle for the RV32M mul/div sequencer
interface alu_muldiv_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    modport master (
        output in_valid, op, opa, opb, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, opa, opb, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - multi-cycle MUL/MULHU/DIVU/REMU sequencer driving the core's shared ALU
module alu_muldiv_seq #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_muldiv_seq_if.slave     io,
    output logic                alu_req,
    output logic [XLEN-1:0]     alu_src1,
    output logic [XLEN-1:0]     alu_src2,
    output logic [3:0]          alu_control,
    input  logic [XLEN-1:0]     alu_result
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    logic [1:0]      state;
    logic [1:0]      op_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] a_q;      // multiplicand or divisor
    logic [XLEN-1:0] hi_q;     // P_hi or partial remainder R
    logic [XLEN-1:0] lo_q;     // P_lo or quotient/dividend Q
    logic [XLEN-1:0] res_q;

    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] hi_nxt;
    logic [XLEN-1:0] lo_nxt;
    logic            carry;
    logic            take;

    assign io.in_ready  = (state == S_IDLE);
    assign io.out_valid = (state == S_DONE);
    assign io.result    = res_q;

    always_comb begin
        rs          = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        alu_req     = (state == S_RUN);
        alu_src1    = '0;
        alu_src2    = '0;
        alu_control = ALU_ADD;
        carry       = 1'b0;
        take        = 1'b0;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        if (state == S_RUN) begin
            if (op_q[1]) begin
                // R[31] set means the shifted remainder overflowed 32 bits, so it always exceeds D
                alu_src1    = rs;
                alu_src2    = a_q;
                alu_control = ALU_SUB;
                take        = hi_q[XLEN-1] | (rs >= a_q);
                hi_nxt      = take ? alu_result : rs;
                lo_nxt      = {lo_q[XLEN-2:0], take};
            end else begin
                alu_src1 = hi_q;
                alu_src2 = lo_q[0] ? a_q : '0;
                carry    = (alu_result < hi_q);
                hi_nxt   = {carry, alu_result[XLEN-1:1]};
                lo_nxt   = {alu_result[0], lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_q  <= '0;
            cnt   <= '0;
            a_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            res_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (io.in_valid) begin
                        op_q <= io.op;
                        cnt  <= '0;
                        hi_q <= '0;
                        if (io.op[1]) begin
                            a_q  <= io.opb;
                            lo_q <= io.opa;
                            if (io.opb == '0) begin
                                res_q <= io.op[0] ? io.opa : '1;
                                state <= S_DONE;
                            end else begin
                                state <= S_RUN;
                            end
                        end else begin
                            a_q   <= io.opa;
                            lo_q  <= io.opb;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    hi_q <= hi_nxt;
                    lo_q <= lo_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // MULHU/REMU take the high word, MUL/DIVU the low word
                        res_q <= op_q[0] ? hi_nxt : lo_nxt;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (io.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - scoreboard bench for alu_muldiv_seq against an arithmetic reference model
module tb_alu_muldiv_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_muldiv_seq_if io();

    logic        alu_req;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;

    // Stand-in for the core's shared ALU
    assign alu_result = (alu_control == 4'b0001) ? alu_src1 - alu_src2 : alu_src1 + alu_src2;

    alu_muldiv_seq #(.XLEN(32), .ITER(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .io          (io),
        .alu_req     (alu_req),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_control (alu_control),
        .alu_result  (alu_result)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] exp;
        int          acc;
        int          lat;
        int          nreq;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic        ov_prev = 1'b0;
    logic        chk_idle = 1'b0;
    logic [31:0] held = '0;
    int          req_cnt = 0;
    logic        rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rand_ready) io.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard when the DUT presents a result
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            ov_prev  = 1'b0;
            req_cnt  = 0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                check("in_ready_after_handshake", 32'(io.in_ready), 32'd1);
                chk_idle = 1'b0;
            end
            if (alu_req) begin
                req_cnt++;
                if (sb.size() > 0) check("alu_control", 32'(alu_control), sb[0].op[1] ? 32'd1 : 32'd0);
            end else begin
                check("alu_idle_src1", alu_src1, 32'd0);
                check("alu_idle_src2", alu_src2, 32'd0);
                check("alu_idle_ctrl", 32'(alu_control), 32'd0);
            end
            if (io.out_valid) begin
                if (!ov_prev) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_out_valid: got result %h with nothing outstanding at cycle %0d", io.result, cyc);
                    end else begin
                        check("result", io.result, sb[0].exp);
                        check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                        check("alu_req_cycles", 32'(req_cnt), 32'(sb[0].nreq));
                    end
                    held = io.result;
                end else begin
                    check("result_stable", io.result, held);
                end
                check("in_ready_in_done", 32'(io.in_ready), 32'd0);
                if (io.out_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    req_cnt  = 0;
                    chk_idle = 1'b1;
                end
            end
            ov_prev = io.out_valid;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!io.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!io.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at cycle %0d", cyc);
        end
        io.in_valid = 1'b1;
        io.op  = op;
        io.opa = a;
        io.opb = b;
        e.op   = op;
        e.exp  = model(op, a, b);
        e.acc  = cyc;
        // accept cycle + 33 for the 32-cycle run, accept + 1 for the divide-by-zero shortcut
        e.lat  = (op[1] && b == 0) ? 1 : 33;
        e.nreq = (op[1] && b == 0) ? 0 : 32;
        sb.push_back(e);
        @(negedge clk);
        io.in_valid = 1'b0;
        io.opa = $urandom;
        io.opb = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        io.in_valid  = 1'b0;
        io.op        = 2'd0;
        io.opa       = '0;
        io.opb       = '0;
        io.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_result", io.result, 32'd0);
        check("rst_alu_req", 32'(alu_req), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(io.in_ready), 32'd1);

        issue(2'd0, 32'd7, 32'd6);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'd2, 32'd100, 32'd7);
        issue(2'd3, 32'd100, 32'd7);
        issue(2'd2, 32'hFFFF_FFFF, 32'h8000_0001);
        issue(2'd3, 32'hFFFF_FFFF, 32'h8000_0001);
        issue(2'd2, 32'd5, 32'd0);
        issue(2'd3, 32'd5, 32'd0);
        drain();

        // Hold the result with out_ready low; a stray request must be ignored
        @(posedge clk);
        #2;
        io.out_ready = 1'b0;
        issue(2'd0, 32'd3, 32'd5);
        n = 0;
        while (!io.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("stall_out_valid", 32'(io.out_valid), 32'd1);
            check("stall_in_ready", 32'(io.in_ready), 32'd0);
            io.in_valid = (i == 4);
            io.op  = 2'd0;
            io.opa = 32'd9;
            io.opb = 32'd9;
            @(negedge clk);
        end
        io.in_valid = 1'b0;
        @(posedge clk);
        #2;
        io.out_ready = 1'b1;
        drain();
        repeat (4) @(negedge clk);

        // Reset ten cycles into a divide: no result may ever appear
        issue(2'd2, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrun_rst_out_valid", 32'(io.out_valid), 32'd0);
        check("midrun_rst_in_ready", 32'(io.in_ready), 32'd1);
        check("midrun_rst_alu_req", 32'(alu_req), 32'd0);
        check("midrun_rst_src1", alu_src1, 32'd0);
        check("midrun_rst_src2", alu_src2, 32'd0);
        check("midrun_rst_result", io.result, 32'd0);
        req_cnt  = 0;
        ov_prev  = 1'b0;
        chk_idle = 1'b0;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(2'd0, 32'd2, 32'd2);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 20);
                2:       b = 32'h8000_0000 | $urandom;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
            issue(2'($urandom_range(0, 3)), a, b);
        end
        drain();
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
